// File: rtl/ibram_reader.sv
// ibram_reader: instruction fetch front end for a single-port BRAM.
// Accepts one word request per cycle and checks it against the mapped
// window. Legal requests are issued to the BRAM in the accept cycle.
// Responses return in order through a 2-entry FIFO, and illegal requests
// come back as error responses.
module ibram_reader #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h1FC0_0000
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [31:0]           req_addr,
  input  logic                  flush,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_err,
  output logic                  bram_en,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic                  bram_we,
  input  logic [DATA_WIDTH-1:0] bram_rdata
);

  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned SHIFT      = ADDR_WIDTH + 2;

  logic [31:0]           offset;
  logic                  addr_legal;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic                  accept;
  logic                  pop;
  logic                  push;
  logic [1:0]            occupancy;
  logic [1:0]            occ_after_pop;

  logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic [1:0]            fifo_err;
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            count;
  logic                  infl_q;
  logic                  infl_err_q;
  logic [ADDR_WIDTH-1:0] bram_addr_q;

  // Address decode: word-aligned and inside the BRAM window (offset wraps mod 2^32)
  always_comb begin
    offset     = req_addr - BASE_ADDR;
    addr_legal = (req_addr[1:0] == 2'b00) && ((offset >> SHIFT) == 32'd0);
    word_addr  = offset[ADDR_WIDTH+1:2];
  end

  // Handshake and BRAM port; a pop in the same cycle frees a slot for a new request
  always_comb begin
    resp_valid    = (count != 2'd0);
    pop           = resp_valid && resp_ready;
    push          = infl_q;
    occupancy     = count + 2'(infl_q);
    occ_after_pop = occupancy - 2'(pop);
    req_ready     = resetn && !flush && (occ_after_pop < 2'(FIFO_DEPTH));
    accept        = req_valid && req_ready;
    bram_en       = accept && addr_legal;
    bram_addr     = bram_en ? word_addr : bram_addr_q;
    bram_we       = 1'b0;
  end

  // Response head; data forced to zero for error entries and when empty
  always_comb begin
    resp_err  = resp_valid && fifo_err[rd_ptr];
    resp_data = (resp_valid && !fifo_err[rd_ptr]) ? fifo_data[rd_ptr] : '0;
  end

  // In-flight slot tracks the request whose BRAM data arrives next cycle
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      infl_q      <= 1'b0;
      infl_err_q  <= 1'b0;
      bram_addr_q <= '0;
    end else begin
      if (flush) begin
        infl_q     <= 1'b0;
        infl_err_q <= 1'b0;
      end else begin
        infl_q     <= accept;
        infl_err_q <= accept && !addr_legal;
      end
      if (bram_en) bram_addr_q <= word_addr;
    end
  end

  // FIFO control: flush empties it; simultaneous push and pop keep count unchanged
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count    <= 2'd0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      fifo_err <= 2'b00;
    end else if (flush) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) begin
        fifo_err[wr_ptr] <= infl_err_q;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end

  // FIFO payload storage; validity is carried by count, so no reset needed
  always_ff @(posedge clk) begin
    if (!flush && push) fifo_data[wr_ptr] <= infl_err_q ? '0 : bram_rdata;
  end

endmodule

// File: tb/tb_ibram_reader.sv
// Directed self-checking bench for ibram_reader with a behavioural BRAM model.
module tb_ibram_reader;

  localparam logic [31:0] BASE = 32'h1FC0_0000;

  logic        clk;
  logic        resetn;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        flush;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        bram_en;
  logic [9:0]  bram_addr;
  logic        bram_we;
  logic [31:0] bram_rdata;

  logic [31:0] mem [0:1023];

  int n_cmp;
  int n_bad;

  ibram_reader #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(10),
    .BASE_ADDR (BASE)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .flush     (flush),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_data (resp_data),
    .resp_err  (resp_err),
    .bram_en   (bram_en),
    .bram_addr (bram_addr),
    .bram_we   (bram_we),
    .bram_rdata(bram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read BRAM: data valid the cycle after bram_en
  always @(posedge clk) begin
    if (bram_en) bram_rdata <= mem[bram_addr];
  end

  function automatic logic [31:0] word_val(input int k);
    if (k == 5) return 32'hDEAD_BEEF;
    return 32'hA000_0000 + 32'(k);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    bram_rdata = 32'h0;
    for (int i = 0; i < 1024; i++) mem[i] = word_val(i);

    // Reset state, with a legal request offered to prove gating
    resetn     = 1'b0;
    req_valid  = 1'b1;
    req_addr   = BASE;
    flush      = 1'b0;
    resp_ready = 1'b1;
    sample();
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_data", 64'(resp_data), 64'd0);
    chk("rst_resp_err", 64'(resp_err), 64'd0);
    chk("rst_bram_en", 64'(bram_en), 64'd0);
    chk("rst_bram_we", 64'(bram_we), 64'd0);
    next_cycle();
    resetn    = 1'b1;
    req_valid = 1'b0;
    sample();
    chk("post_rst_req_ready", 64'(req_ready), 64'd1);
    chk("post_rst_resp_valid", 64'(resp_valid), 64'd0);

    // Single read of word 5
    next_cycle();
    req_valid = 1'b1;
    req_addr  = 32'h1FC0_0014;
    sample();
    chk("single_bram_en", 64'(bram_en), 64'd1);
    chk("single_bram_addr", 64'(bram_addr), 64'd5);
    next_cycle();
    req_valid = 1'b0;
    sample();
    chk("single_c1_valid", 64'(resp_valid), 64'd0);
    chk("single_c1_en", 64'(bram_en), 64'd0);
    chk("single_c1_addr_hold", 64'(bram_addr), 64'd5);
    next_cycle();
    sample();
    chk("single_c2_valid", 64'(resp_valid), 64'd1);
    chk("single_c2_data", 64'(resp_data), 64'hDEAD_BEEF);
    chk("single_c2_err", 64'(resp_err), 64'd0);
    next_cycle();
    sample();
    chk("single_c3_valid", 64'(resp_valid), 64'd0);

    // Streaming words 0..7 back to back
    for (int c = 0; c < 11; c++) begin
      next_cycle();
      req_valid = (c < 8);
      req_addr  = BASE + 32'(4 * c);
      sample();
      if (c < 8) chk($sformatf("stream_ready_%0d", c), 64'(req_ready), 64'd1);
      if (c >= 2 && c < 10) begin
        chk($sformatf("stream_valid_%0d", c), 64'(resp_valid), 64'd1);
        chk($sformatf("stream_data_%0d", c), 64'(resp_data), 64'(word_val(c - 2)));
      end
      if (c == 10) chk("stream_drained", 64'(resp_valid), 64'd0);
    end

    // Backpressure: two accepted, third stalls until a pop
    next_cycle();
    resp_ready = 1'b0;
    req_valid  = 1'b1;
    req_addr   = BASE + 32'd4;
    sample();
    chk("bp_a_ready", 64'(req_ready), 64'd1);
    next_cycle();
    req_addr = BASE + 32'd8;
    sample();
    chk("bp_b_ready", 64'(req_ready), 64'd1);
    next_cycle();
    req_addr = BASE + 32'd12;
    sample();
    chk("bp_c_stall", 64'(req_ready), 64'd0);
    chk("bp_c_nobram", 64'(bram_en), 64'd0);
    chk("bp_head_a", 64'(resp_data), 64'(word_val(1)));
    for (int c = 0; c < 2; c++) begin
      next_cycle();
      sample();
      chk($sformatf("bp_stall_%0d", c), 64'(req_ready), 64'd0);
      chk($sformatf("bp_hold_valid_%0d", c), 64'(resp_valid), 64'd1);
      chk($sformatf("bp_hold_data_%0d", c), 64'(resp_data), 64'(word_val(1)));
    end
    next_cycle();
    resp_ready = 1'b1;
    sample();
    chk("bp_c_accept", 64'(req_ready), 64'd1);
    chk("bp_c_bram_addr", 64'(bram_addr), 64'd3);
    chk("bp_pop_a", 64'(resp_data), 64'(word_val(1)));
    next_cycle();
    req_valid = 1'b0;
    sample();
    chk("bp_head_b", 64'(resp_data), 64'(word_val(2)));
    next_cycle();
    sample();
    chk("bp_head_c", 64'(resp_data), 64'(word_val(3)));
    chk("bp_head_c_valid", 64'(resp_valid), 64'd1);
    next_cycle();
    sample();
    chk("bp_drained", 64'(resp_valid), 64'd0);

    // Error responses: misaligned, then one past the window
    next_cycle();
    req_valid = 1'b1;
    req_addr  = 32'h1FC0_0002;
    sample();
    chk("err_mis_ready", 64'(req_ready), 64'd1);
    chk("err_mis_en", 64'(bram_en), 64'd0);
    next_cycle();
    req_addr = 32'h1FC0_1000;
    sample();
    chk("err_oor_en", 64'(bram_en), 64'd0);
    chk("err_addr_hold", 64'(bram_addr), 64'd3);
    next_cycle();
    req_valid = 1'b0;
    sample();
    chk("err1_valid", 64'(resp_valid), 64'd1);
    chk("err1_err", 64'(resp_err), 64'd1);
    chk("err1_data", 64'(resp_data), 64'd0);
    next_cycle();
    sample();
    chk("err2_valid", 64'(resp_valid), 64'd1);
    chk("err2_err", 64'(resp_err), 64'd1);
    chk("err2_data", 64'(resp_data), 64'd0);
    next_cycle();
    sample();
    chk("err_drained", 64'(resp_valid), 64'd0);

    // Window edges: last word legal, address just below base wraps illegal
    next_cycle();
    req_valid = 1'b1;
    req_addr  = 32'h1FC0_0FFC;
    sample();
    chk("edge_top_en", 64'(bram_en), 64'd1);
    chk("edge_top_addr", 64'(bram_addr), 64'd1023);
    next_cycle();
    req_addr = 32'h1FBF_FFFC;
    sample();
    chk("edge_below_en", 64'(bram_en), 64'd0);
    next_cycle();
    req_valid = 1'b0;
    sample();
    chk("edge_top_data", 64'(resp_data), 64'(word_val(1023)));
    chk("edge_top_err", 64'(resp_err), 64'd0);
    next_cycle();
    sample();
    chk("edge_below_err", 64'(resp_err), 64'd1);
    next_cycle();
    sample();
    chk("edge_drained", 64'(resp_valid), 64'd0);

    // Flush with one entry in FIFO and one in flight; pop in flush cycle
    next_cycle();
    resp_ready = 1'b0;
    req_valid  = 1'b1;
    req_addr   = BASE + 32'd4;
    next_cycle();
    req_addr = BASE + 32'd8;
    next_cycle();
    req_valid  = 1'b0;
    flush      = 1'b1;
    resp_ready = 1'b1;
    sample();
    chk("flush_ready", 64'(req_ready), 64'd0);
    next_cycle();
    flush     = 1'b0;
    req_valid = 1'b1;
    req_addr  = BASE + 32'd12;
    sample();
    chk("flush_after_valid", 64'(resp_valid), 64'd0);
    chk("flush_after_ready", 64'(req_ready), 64'd1);
    next_cycle();
    req_valid = 1'b0;
    sample();
    chk("flush_gap_valid", 64'(resp_valid), 64'd0);
    next_cycle();
    sample();
    chk("flush_w3_valid", 64'(resp_valid), 64'd1);
    chk("flush_w3_data", 64'(resp_data), 64'(word_val(3)));
    next_cycle();
    sample();
    chk("flush_drained", 64'(resp_valid), 64'd0);

    // Asynchronous reset with the FIFO full
    next_cycle();
    resp_ready = 1'b0;
    req_valid  = 1'b1;
    req_addr   = BASE + 32'd4;
    next_cycle();
    req_addr = BASE + 32'd8;
    next_cycle();
    req_valid = 1'b0;
    next_cycle();
    sample();
    chk("full_valid", 64'(resp_valid), 64'd1);
    chk("full_ready", 64'(req_ready), 64'd0);
    #2;
    resetn = 1'b0;
    #1;
    chk("async_rst_valid", 64'(resp_valid), 64'd0);
    chk("async_rst_ready", 64'(req_ready), 64'd0);
    next_cycle();
    resetn     = 1'b1;
    resp_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      sample();
      chk($sformatf("post_async_valid_%0d", c), 64'(resp_valid), 64'd0);
      chk($sformatf("post_async_ready_%0d", c), 64'(req_ready), 64'd1);
      next_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
